// File: rtl/matmul_axis_coproc_pkg.sv
// matmul_axis_coproc_pkg: shared FSM states, stream width and address-width helper
package matmul_axis_coproc_pkg;
  typedef enum logic [1:0] {RECV, COMPUTE, SEND} state_t;
  localparam int AXIS_W = 32;
  function automatic int addr_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/matmul_axis_coproc_if.sv
// matmul_axis_coproc_if: AXI4-Stream channel with master/slave views
interface matmul_axis_coproc_if;
  logic tvalid;
  logic tready;
  logic tlast;
  logic [matmul_axis_coproc_pkg::AXIS_W-1:0] tdata;
  modport master(output tvalid, tdata, tlast, input tready);
  modport slave(input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/matmul_axis_coproc_mem.sv
// matmul_axis_coproc_mem: single-clock RAM, one write port and one registered read port
module matmul_axis_coproc_mem import matmul_axis_coproc_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int AW = addr_w(DEPTH)
) (
  input  logic             ACLK,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  // write when enabled, read every cycle
  always_ff @(posedge ACLK) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/matmul_axis_coproc.sv
// matmul_axis_coproc: streams in A then B, computes A*B one MAC per cycle, streams out scaled RES
module matmul_axis_coproc import matmul_axis_coproc_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int A_ROWS = 2,
  parameter int A_COLS = 4,
  parameter int B_COLS = 1,
  parameter int OUT_SHIFT = 8,
  parameter bit SATURATE = 1
) (
  input  logic ACLK,
  input  logic ARESET,
  matmul_axis_coproc_if.slave  s_axis,
  matmul_axis_coproc_if.master m_axis,
  output logic FRAME_ERR
);
  localparam int NA = A_ROWS * A_COLS;
  localparam int NB = A_COLS * B_COLS;
  localparam int N_IN = NA + NB;
  localparam int N_OUT = A_ROWS * B_COLS;
  localparam int ACC_W = 2 * WIDTH + $clog2(A_COLS);
  localparam int AWA = addr_w(NA);
  localparam int AWB = addr_w(NB);
  localparam int AWR = addr_w(N_OUT);
  localparam int IW = addr_w(N_IN);
  localparam int PW = addr_w(A_COLS + 1);
  localparam int RW = addr_w(A_ROWS);
  localparam int CW = addr_w(B_COLS);
  localparam logic [ACC_W-1:0] MAX = ACC_W'({WIDTH{1'b1}});
  state_t state, state_nx;
  logic s_rdy, s_rdy_nx, m_vld, m_vld_nx;
  logic [IW-1:0] in_cnt;
  logic [PW-1:0] p, k;
  logic [RW-1:0] r;
  logic [CW-1:0] c;
  logic [AWR-1:0] e, o;
  logic [ACC_W-1:0] acc, sum, shifted;
  logic [WIDTH-1:0] rd_a, rd_b, rd_r, res;
  logic hs_in, hs_out, in_last, k_last, e_last, o_last, c_last, r_last, we_a;
  logic unused_hi;
  assign hs_in = s_axis.tvalid && s_rdy;
  assign hs_out = m_vld && m_axis.tready;
  assign in_last = in_cnt == IW'(N_IN - 1);
  assign k_last = p == PW'(A_COLS);
  assign e_last = e == AWR'(N_OUT - 1);
  assign o_last = o == AWR'(N_OUT - 1);
  assign c_last = c == CW'(B_COLS - 1);
  assign r_last = r == RW'(A_ROWS - 1);
  assign k = k_last ? '0 : p;
  assign we_a = hs_in && (32'(in_cnt) < NA);
  assign sum = acc + ACC_W'(rd_a) * ACC_W'(rd_b);
  assign shifted = sum >> OUT_SHIFT;
  assign res = (SATURATE && shifted > MAX) ? '1 : shifted[WIDTH-1:0];
  assign unused_hi = ^s_axis.tdata[AXIS_W-1:WIDTH];
  assign s_axis.tready = s_rdy;
  assign m_axis.tvalid = m_vld;
  assign m_axis.tdata = m_vld ? AXIS_W'(rd_r) : '0;
  assign m_axis.tlast = m_vld && o_last;
  matmul_axis_coproc_mem #(.DEPTH(NA), .WIDTH(WIDTH)) u_a (
    .ACLK(ACLK), .we(we_a), .waddr(AWA'(in_cnt)), .wdata(s_axis.tdata[WIDTH-1:0]),
    .raddr(AWA'(r * A_COLS + k)), .rdata(rd_a)
  );
  matmul_axis_coproc_mem #(.DEPTH(NB), .WIDTH(WIDTH)) u_b (
    .ACLK(ACLK), .we(hs_in && !we_a), .waddr(AWB'(in_cnt - NA)), .wdata(s_axis.tdata[WIDTH-1:0]),
    .raddr(AWB'(k * B_COLS + c)), .rdata(rd_b)
  );
  matmul_axis_coproc_mem #(.DEPTH(N_OUT), .WIDTH(WIDTH)) u_res (
    .ACLK(ACLK), .we(state == COMPUTE && k_last), .waddr(e), .wdata(res),
    .raddr((hs_out && !o_last) ? AWR'(o + 1'b1) : o), .rdata(rd_r)
  );
  // next state; ready/valid are registered so they follow the state they lead into
  always_comb begin
    state_nx = (state == RECV && hs_in && in_last) ? COMPUTE :
               (state == COMPUTE && k_last && e_last) ? SEND :
               (state == SEND && hs_out && o_last) ? RECV : state;
    s_rdy_nx = state_nx == RECV;
    m_vld_nx = state == SEND && !(hs_out && o_last);
  end
  // state and handshake flags; first SEND cycle prefetches RES[0] with valid still low
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state <= RECV;
      s_rdy <= 1'b0;
      m_vld <= 1'b0;
    end else begin
      state <= state_nx;
      s_rdy <= s_rdy_nx;
      m_vld <= m_vld_nx;
    end
  end
  // input, MAC and output counters; phase 0 waits for read data, phase A_COLS stores the element
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      in_cnt <= '0;
      p <= '0;
      r <= '0;
      c <= '0;
      e <= '0;
      o <= '0;
      acc <= '0;
      FRAME_ERR <= 1'b0;
    end else begin
      FRAME_ERR <= hs_in && (s_axis.tlast != in_last);
      if (hs_in) in_cnt <= in_last ? '0 : in_cnt + 1'b1;
      if (state == COMPUTE) begin
        p <= k_last ? '0 : p + 1'b1;
        acc <= (p == '0 || k_last) ? '0 : sum;
        if (k_last) begin
          e <= e_last ? '0 : e + 1'b1;
          c <= c_last ? '0 : c + 1'b1;
          if (c_last) r <= r_last ? '0 : r + 1'b1;
        end
      end
      if (hs_out) o <= o_last ? '0 : o + 1'b1;
    end
  end
endmodule
